// File: rtl/if_fetch_queue.sv
// Instruction prefetch FIFO between IF_Stage and IF_Stage_Reg.
// First-word fall-through head, full flag back-pressures fetch, flush empties it.
module if_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   PC_in,
    input  logic [31:0]   Instruction_in,
    input  logic          freeze,
    input  logic          flush,
    output logic          freeze_if,
    output logic          out_valid,
    output logic [31:0]   PC,
    output logic [31:0]   Instruction,
    output logic [AW:0]   level
);

    localparam logic [AW:0] LVL_FULL = DEPTH[AW:0];

    logic [63:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;

    logic          w_push;
    logic          w_pop;
    logic [63:0]   w_head;

    assign freeze_if = (r_level == LVL_FULL);
    assign out_valid = (r_level != '0);
    assign w_push    = in_valid & ~freeze_if;
    assign w_pop     = out_valid & ~freeze;

    assign w_head      = r_mem[r_rd_ptr];
    assign PC          = out_valid ? w_head[63:32] : 32'h0;
    assign Instruction = out_valid ? w_head[31:0]  : 32'h0;
    assign level       = r_level;

    // Storage needs no reset; only entries covered by level are ever observed.
    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wr_ptr] <= {PC_in, Instruction_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: queue-based reference model plus a negedge monitor,
// directed scenarios followed by randomized traffic.
module tb_if_fetch_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [31:0]   PC_in;
    logic [31:0]   Instruction_in;
    logic          freeze;
    logic          flush;
    logic          freeze_if;
    logic          out_valid;
    logic [31:0]   PC;
    logic [31:0]   Instruction;
    logic [AW:0]   level;

    int nvec = 0;
    int nerr = 0;

    // Expected queue contents, head at index 0: {PC, Instruction}.
    logic [63:0] model_q [$];

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .PC_in(PC_in),
        .Instruction_in(Instruction_in), .freeze(freeze), .flush(flush),
        .freeze_if(freeze_if), .out_valid(out_valid), .PC(PC),
        .Instruction(Instruction), .level(level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a plain bounded queue updated from the inputs seen at each edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_q.delete();
        end else if (flush) begin
            model_q.delete();
        end else begin
            automatic bit do_push = in_valid && (model_q.size() < DEPTH);
            automatic bit do_pop  = (model_q.size() > 0) && !freeze;
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back({PC_in, Instruction_in});
        end
    end

    // Monitor: compare the presented head and status against the model every cycle.
    always @(negedge clk) begin
        automatic logic [63:0] exp_head = (model_q.size() > 0) ? model_q[0] : 64'h0;
        check("mon_level",     32'(level),     32'(model_q.size()));
        check("mon_out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check("mon_freeze_if", 32'(freeze_if), 32'(model_q.size() == DEPTH));
        check("mon_PC",        PC,             exp_head[63:32]);
        check("mon_Instr",     Instruction,    exp_head[31:0]);
    end

    // Apply inputs for one edge, then return just after that edge.
    task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                         input logic frz, input logic fl);
        in_valid       = iv;
        PC_in          = pc;
        Instruction_in = ins;
        freeze         = frz;
        flush          = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; PC_in = '0; Instruction_in = '0;
        freeze = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_level",     32'(level),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_freeze_if", 32'(freeze_if), 32'd0);
        check("rst_PC",        PC,             32'd0);
        rst = 1'b0;

        // Fill under freeze, fifth push must be ignored.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'(4 + 4*i), 32'hA000_0000 + 32'(i), 1'b1, 1'b0);
            check("fill_level", 32'(level), 32'(i + 1));
        end
        check("fill_freeze_if", 32'(freeze_if), 32'd1);
        drive(1'b1, 32'd20, 32'hA000_0004, 1'b1, 1'b0);
        check("fill5_level", 32'(level), 32'd4);
        check("fill5_PC",    PC,          32'd4);
        check("fill5_Instr", Instruction, 32'hA000_0000);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
            check("drain_PC", PC, (i < 3) ? 32'(8 + 4*i) : 32'd0);
        end
        check("drain_out_valid", 32'(out_valid), 32'd0);

        // Streaming at level 2 across pointer wrap.
        drive(1'b1, 32'h100, 32'hB000_0000, 1'b1, 1'b0);
        drive(1'b1, 32'h104, 32'hB000_0001, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(32'h108 + 4*i), 32'hB000_0002 + 32'(i), 1'b0, 1'b0);
            check("stream_level", 32'(level), 32'd2);
            check("stream_PC",    PC, 32'(32'h104 + 4*i));
        end
        repeat (3) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Flush with a simultaneous push.
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'(32'h18 + 4*i), 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
        check("preflush_level", 32'(level), 32'd3);
        drive(1'b1, 32'h24, 32'hC000_0024, 1'b0, 1'b1);
        check("flush_level",     32'(level),     32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        drive(1'b1, 32'h28, 32'hC000_0028, 1'b1, 1'b0);
        check("postflush_PC",    PC,          32'h28);
        check("postflush_Instr", Instruction, 32'hC000_0028);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Reset pulsed between edges mid-fill.
        drive(1'b1, 32'h40, 32'hD000_0000, 1'b1, 1'b0);
        drive(1'b1, 32'h44, 32'hD000_0001, 1'b1, 1'b0);
        check("prerst_level", 32'(level), 32'd2);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("arst_level",     32'(level),     32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_PC",        PC,             32'd0);
        check("arst_Instr",     Instruction,    32'd0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 32'h48, 32'hD000_0002, 1'b1, 1'b0);
        check("postrst_PC", PC, 32'h48);
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            drive(1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
        repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
